// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory slave for the CPU load/store port. Accepts one request at a
//   time on a valid/ready request channel. After LATENCY cycles it performs
//   the access and presents the result on a valid/ready response channel.
//   Supports byte/half/word stores and sign- or zero-extended loads.
//   Misaligned, out-of-range and illegal-size accesses return rsp_err and
//   leave the RAM untouched.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_wdata     store data, LSB-justified
//   req_size      00 = byte, 01 = half, 10 = word, 11 = illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata     load data (0 for stores and errors)
//   rsp_err       access error flag
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  req_t            r;
  logic [CW-1:0]   cnt;
  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Access decode from the latched request
  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            err;
  logic [3:0][7:0] word;
  logic [15:0]     hw;
  logic [31:0]     ld;
  logic [3:0]      be;
  logic [3:0][7:0] wrep;
  logic            do_access;
  logic            do_write;

  always_comb begin
    off  = r.addr - BASE_ADDR;          // 32-bit wrap is intended
    idx  = off[AW+1:2];
    lane = off[1:0];
    err  = (r.size == 2'b11) ||
           (r.size == 2'b01 && lane[0]) ||
           (r.size == 2'b10 && lane != 2'b00) ||
           (off >= SPAN);
    word = mem[idx];
    hw   = lane[1] ? word[3:2] : word[1:0];
    case (r.size)
      2'b00:   ld = r.uns ? {24'b0, word[lane]} : {{24{word[lane][7]}}, word[lane]};
      2'b01:   ld = r.uns ? {16'b0, hw} : {{16{hw[15]}}, hw};
      default: ld = word;
    endcase
    // Replicate store data across lanes; byte enables pick the target lanes
    case (r.size)
      2'b00:   begin be = 4'b0001 << lane; wrep = {4{r.wdata[7:0]}};  end
      2'b01:   begin be = 4'b0011 << lane; wrep = {2{r.wdata[15:0]}}; end
      default: begin be = 4'b1111;         wrep = r.wdata;            end
    endcase
    do_access = (state == BUSY) && (cnt == '0);
    do_write  = do_access && r.we && !err;
  end

  // RAM has no reset; a reset forces state to IDLE so no write can follow
  always_ff @(posedge clk) begin
    if (do_write)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][b] <= wrep[b];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      r         <= '0;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            r         <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                           size: req_size, uns: req_unsigned};
            cnt       <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= BUSY;
          end else begin
            req_ready <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || r.we) ? 32'h0 : ld;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // req_ready rises on the handshake edge; the earliest accept is the next edge
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_rdata, input logic exp_err, input string nm);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Present a request and hold it until accepted; returns 1 ns after the accept edge
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    int k;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) timeout_fail("req_accept");
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count edges after accept until rsp_valid; does not handshake
  task automatic wait_rsp(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1 edges++;
    end while (!rsp_valid && edges < 50);
    if (!rsp_valid) timeout_fail("rsp_wait");
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    issue(v.we, v.addr, v.wdata, v.size, v.uns);
    chk({v.nm, " busy_req_ready"}, 32'(req_ready), 32'h0);
    wait_rsp(edges);
    chk({v.nm, " latency"}, 32'(edges), 32'd2);
    chk({v.nm, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({v.nm, " err"}, 32'(rsp_err), 32'(v.exp_err));
    handshake();
    chk({v.nm, " cleared"}, {rsp_rdata[31:1], rsp_rdata[0] | rsp_valid | rsp_err}, 32'h0);
  endtask

  initial begin
    int edges;
    logic [31:0] held;

    // word 0 seeded so the out-of-range store at 0x400 (aliases idx 0) is detectable
    add(1, 32'h0,   32'hA5A5A5A5, 2'b10, 0, 32'h0,        0, "seed_w0");
    add(1, 32'h10,  32'hDEADBEEF, 2'b10, 0, 32'h0,        0, "st_word");
    add(0, 32'h10,  32'h0,        2'b10, 0, 32'hDEADBEEF, 0, "ld_word");
    add(1, 32'h10,  32'h0,        2'b10, 0, 32'h0,        0, "clr_word");
    add(1, 32'h11,  32'h80,       2'b00, 0, 32'h0,        0, "st_byte");
    add(0, 32'h11,  32'h0,        2'b00, 0, 32'hFFFFFF80, 0, "ld_byte_s");
    add(0, 32'h11,  32'h0,        2'b00, 1, 32'h00000080, 0, "ld_byte_u");
    add(0, 32'h10,  32'h0,        2'b10, 0, 32'h00008000, 0, "ld_word_b");
    add(0, 32'h13,  32'h0,        2'b01, 0, 32'h0,        1, "ld_half_mis");
    add(1, 32'h12,  32'hFFFFFFFF, 2'b10, 0, 32'h0,        1, "st_word_mis");
    add(0, 32'h10,  32'h0,        2'b10, 0, 32'h00008000, 0, "ld_after_mis");
    add(0, 32'h400, 32'h0,        2'b10, 0, 32'h0,        1, "ld_oor");
    add(1, 32'h400, 32'h55555555, 2'b10, 0, 32'h0,        1, "st_oor");
    add(0, 32'h10,  32'h0,        2'b11, 0, 32'h0,        1, "ld_size11");
    add(1, 32'h10,  32'h77777777, 2'b11, 0, 32'h0,        1, "st_size11");
    add(0, 32'h0,   32'h0,        2'b10, 0, 32'hA5A5A5A5, 0, "w0_intact");
    add(0, 32'h10,  32'h0,        2'b10, 0, 32'h00008000, 0, "w10_intact");
    add(1, 32'h20,  32'h11223344, 2'b10, 0, 32'h0,        0, "st_w20");
    add(1, 32'h22,  32'h0000BEEF, 2'b01, 0, 32'h0,        0, "st_half");
    add(0, 32'h20,  32'h0,        2'b10, 0, 32'hBEEF3344, 0, "ld_w20");
    add(0, 32'h22,  32'h0,        2'b01, 0, 32'hFFFFBEEF, 0, "ld_half_s");
    add(0, 32'h20,  32'h0,        2'b01, 1, 32'h00003344, 0, "ld_half_u");
    add(0, 32'h23,  32'h0,        2'b00, 0, 32'hFFFFFFBE, 0, "ld_byte3_s");
    add(1, 32'h3FC, 32'hCAFEF00D, 2'b10, 0, 32'h0,        0, "st_top");
    add(0, 32'h3FC, 32'h0,        2'b10, 0, 32'hCAFEF00D, 0, "ld_top");

    // Reset state
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rel_req_ready_pre", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 chk("rel_req_ready", 32'(req_ready), 32'h1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Response held off for 5 cycles; a competing store must be ignored
    issue(0, 32'h20, 32'h0, 2'b10, 0);
    wait_rsp(edges);
    held = rsp_rdata;
    chk("hold_first", held, 32'hBEEF3344);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_size = 2'b10;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rdata", rsp_rdata, held);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
    end
    handshake();
    req_valid = 1'b0;
    chk("post_hs_req_ready", 32'(req_ready), 32'h1);
    chk("post_hs_valid", 32'(rsp_valid), 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("ignored_no_rsp", 32'(rsp_valid), 32'h0);
    run_vec('{0, 32'h20, 32'h0, 2'b10, 0, 32'hBEEF3344, 0, "ignored_store"});

    // Reset while a store is in BUSY: nothing written, nothing answered
    issue(1, 32'h20, 32'h12345678, 2'b10, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("midrst_no_rsp", 32'(rsp_valid), 32'h0);
    run_vec('{0, 32'h20, 32'h0, 2'b10, 0, 32'hBEEF3344, 0, "midrst_unwritten"});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
